counter_udm: RTL and testbench

COUNTER_UDM -- requirements
Module: counter_udm

---
 rtl/counter_udm.sv | 65 ++++++
 tb/tb_counter_udm.sv | 134 +++++++++++++
 2 files changed

// File: rtl/counter_udm.sv
// counter_udm: up/down modulo counter with clear, clamped load, wrap/saturate limits and terminal-count pulse.
// Optional sticky overflow flag (ovf_clr/ovf_sticky) is compiled in with COUNTER_UDM_STICKY_EN.
module counter_udm #(
  parameter int WIDTH    = 8,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_,
`ifdef COUNTER_UDM_STICKY_EN
  input  logic             ovf_clr,
  output logic             ovf_sticky,
`endif
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             zero
);
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             at_top, at_bot, above;
  always_comb begin
    at_top = count_q >= mod_val;
    at_bot = count_q == '0;
    above  = count_q > mod_val;
    count_d = count_q;
    tc_d    = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = (data > mod_val) ? mod_val : data;
    end else if (en && up) begin
      count_d = at_top ? (SATURATE ? mod_val : '0) : count_q + WIDTH'(1);
      tc_d    = at_top;
    end else if (en) begin
      // A lowered mod_val pulls the count back into range before any wrap logic applies.
      count_d = at_bot ? (SATURATE ? '0 : mod_val) : above ? mod_val : count_q - WIDTH'(1);
      tc_d    = at_bot;
    end
  end
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      count_q <= '0;
      tc_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end
`ifdef COUNTER_UDM_STICKY_EN
  logic ovf_q;
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) ovf_q <= 1'b0;
    else       ovf_q <= tc_d ? 1'b1 : ovf_clr ? 1'b0 : ovf_q;
  end
  assign ovf_sticky = ovf_q;
`endif
  assign count = count_q;
  assign tc    = tc_q;
  assign zero  = count_q == '0;
endmodule

// File: tb/tb_counter_udm.sv
// tb_counter_udm: directed checks of counter_udm, one wrapping and one saturating instance sharing stimulus.
module tb_counter_udm;
  logic       clk = 1'b0;
  logic       rst_ = 1'b0;
  logic       en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
  logic [7:0] data = '0, mod_val = 8'd9;
  logic [7:0] cnt0, cnt1;
  logic       tc0, tc1, z0, z1;
  int         n_cmp = 0, n_err = 0;
`ifdef COUNTER_UDM_STICKY_EN
  logic ovf_clr = 1'b0;
  logic st0, st1;
`endif

  always #5 clk = ~clk;

  counter_udm #(.WIDTH(8), .SATURATE(1'b0)) u0 (
    .clk(clk), .rst_(rst_),
`ifdef COUNTER_UDM_STICKY_EN
    .ovf_clr(ovf_clr), .ovf_sticky(st0),
`endif
    .en(en), .up(up), .clr(clr), .load(load), .data(data), .mod_val(mod_val),
    .count(cnt0), .tc(tc0), .zero(z0));

  counter_udm #(.WIDTH(8), .SATURATE(1'b1)) u1 (
    .clk(clk), .rst_(rst_),
`ifdef COUNTER_UDM_STICKY_EN
    .ovf_clr(ovf_clr), .ovf_sticky(st1),
`endif
    .en(en), .up(up), .clr(clr), .load(load), .data(data), .mod_val(mod_val),
    .count(cnt1), .tc(tc1), .zero(z1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic both(input string tag, input logic [7:0] e0, input logic t0, input logic [7:0] e1, input logic t1);
    chk({tag, " cnt0"}, cnt0, e0);
    chk({tag, " tc0"}, tc0, t0);
    chk({tag, " cnt1"}, cnt1, e1);
    chk({tag, " tc1"}, tc1, t1);
  endtask

  initial begin
    #2;
    both("reset", 8'd0, 1'b0, 8'd0, 1'b0);
    chk("reset zero0", z0, 1'b1);
    step();
    rst_ = 1'b1;
    step();
    both("idle after reset", 8'd0, 1'b0, 8'd0, 1'b0);
    // Wrap up with mod_val 9
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      both($sformatf("up %0d", i), 8'(i), 1'b0, 8'(i), 1'b0);
    end
    chk("zero0 at 9", z0, 1'b0);
    step();
    both("up wrap", 8'd0, 1'b1, 8'd9, 1'b1);
    chk("zero0 after wrap", z0, 1'b1);
    en = 1'b0;
    step();
    both("idle tc drop", 8'd0, 1'b0, 8'd9, 1'b0);
    // Wrap down
    en = 1'b1; up = 1'b0;
    step();
    both("down wrap", 8'd9, 1'b1, 8'd8, 1'b0);
    step();
    both("down after wrap", 8'd8, 1'b0, 8'd7, 1'b0);
    // Saturate at 200
    en = 1'b0; mod_val = 8'd200; load = 1'b1; data = 8'd198;
    step();
    both("load 198", 8'd198, 1'b0, 8'd198, 1'b0);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step(); both("sat 1", 8'd199, 1'b0, 8'd199, 1'b0);
    step(); both("sat 2", 8'd200, 1'b0, 8'd200, 1'b0);
    step(); both("sat 3", 8'd0, 1'b1, 8'd200, 1'b1);
    step(); both("sat 4", 8'd1, 1'b0, 8'd200, 1'b1);
    // Priority and clamp
    clr = 1'b1; load = 1'b1; data = 8'd77;
    step(); both("clr priority", 8'd0, 1'b0, 8'd0, 1'b0);
    clr = 1'b0; data = 8'd50; mod_val = 8'd20;
    step(); both("load clamp", 8'd20, 1'b0, 8'd20, 1'b0);
    load = 1'b0; up = 1'b0; mod_val = 8'd10;
    step(); both("down above mod", 8'd10, 1'b0, 8'd10, 1'b0);
    clr = 1'b1;
    step(); both("clr", 8'd0, 1'b0, 8'd0, 1'b0);
    clr = 1'b0;
    step(); both("down at zero", 8'd10, 1'b1, 8'd0, 1'b1);
    // mod_val = 0
    clr = 1'b1;
    step();
    clr = 1'b0; mod_val = 8'd0; up = 1'b1;
    step(); both("mod0 up a", 8'd0, 1'b1, 8'd0, 1'b1);
    step(); both("mod0 up b", 8'd0, 1'b1, 8'd0, 1'b1);
    up = 1'b0;
    step(); both("mod0 down", 8'd0, 1'b1, 8'd0, 1'b1);
    // Async reset between edges
    en = 1'b0; mod_val = 8'd9; load = 1'b1; data = 8'd7;
    step(); both("load 7", 8'd7, 1'b0, 8'd7, 1'b0);
    load = 1'b0;
    #1 rst_ = 1'b0;
    #1 both("async reset", 8'd0, 1'b0, 8'd0, 1'b0);
    #1 rst_ = 1'b1;
    step(); both("hold after reset", 8'd0, 1'b0, 8'd0, 1'b0);
    en = 1'b1; up = 1'b1;
    step(); both("first step", 8'd1, 1'b0, 8'd1, 1'b0);
`ifdef COUNTER_UDM_STICKY_EN
    chk("sticky clear", st0, 1'b0);
    mod_val = 8'd1;
    step(); chk("sticky set", st0, 1'b1); chk("sticky set tc", tc0, 1'b1);
    en = 1'b0;
    step(); chk("sticky hold", st0, 1'b1);
    ovf_clr = 1'b1;
    step(); chk("sticky cleared", st0, 1'b0);
    en = 1'b1;
    step(); chk("sticky no tc", st0, 1'b0); chk("cnt0 to 1", cnt0, 8'd1);
    step(); chk("sticky set wins", st0, 1'b1); chk("sticky set wins tc", tc0, 1'b1);
    ovf_clr = 1'b0;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
